// File: rtl/mmio_region_ctrl.sv
// mmio_region_ctrl: decodes CPU accesses into NUM_REGIONS base/size windows,
// inserts per-region wait states, registers read data and keeps an error log
// (count, first faulting address, sticky flag) for accesses that hit no region.
module mmio_region_ctrl #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int NUM_REGIONS = 8,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE =
        {16'hC000, 16'hA000, 16'h9000, 16'h8000, 16'h4800, 16'h2400, 16'h4800, 16'h0000},
    parameter logic [NUM_REGIONS*5-1:0] REGION_SZLOG2 =
        {5'd10, 5'd8, 5'd12, 5'd12, 5'd6, 5'd13, 5'd7, 5'd13},
    parameter logic [NUM_REGIONS*4-1:0] REGION_WAIT =
        {4'd1, 4'd2, 4'd5, 4'd0, 4'd2, 4'd3, 4'd1, 4'd0},
    parameter logic [ADDR_W-1:0] ERR_ADDR = 16'h48F0
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [ADDR_W-1:0]             cpu_addr_i,
    input  logic                          cpu_rd_i,
    input  logic                          cpu_wr_i,
    input  logic [DATA_W-1:0]             cpu_wdata_i,
    output logic [DATA_W-1:0]             cpu_rdata_o,
    output logic                          cpu_ready_o,
    output logic [NUM_REGIONS-1:0]        reg_sel_o,
    output logic [ADDR_W-1:0]             reg_addr_o,
    output logic                          reg_wr_o,
    output logic [DATA_W-1:0]             reg_wdata_o,
    input  logic [NUM_REGIONS*DATA_W-1:0] reg_rdata_i,
    output logic                          bus_err_o
);

    localparam logic [ADDR_W-1:0] ERR_ADDR1 = ERR_ADDR + 1'b1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    is_wr_q, is_wr_d;
    logic                    miss_q, miss_d;
    logic [NUM_REGIONS-1:0]  sel_q, sel_d;
    logic [ADDR_W-1:0]       off_q, off_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;
    logic [7:0]              err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0]       err_addr_q, err_addr_d;
    logic                    err_sticky_q, err_sticky_d;

    logic [NUM_REGIONS-1:0]  hit;
    logic                    hit_any;
    logic [NUM_REGIONS-1:0]  hit_onehot;
    logic [3:0]              hit_wait;
    logic [ADDR_W-1:0]       hit_off;
    logic [DATA_W-1:0]       rdata_masked [NUM_REGIONS];
    logic [DATA_W-1:0]       sel_rdata;
    logic [DATA_W-1:0]       err_status;

    // Per-region window compare and read-data gating by the held select
    for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
        assign hit[gi] = (cpu_addr_i >> REGION_SZLOG2[gi*5 +: 5]) ==
                         (REGION_BASE[gi*ADDR_W +: ADDR_W] >> REGION_SZLOG2[gi*5 +: 5]);
        assign rdata_masked[gi] = reg_rdata_i[gi*DATA_W +: DATA_W] & {DATA_W{sel_q[gi]}};
    end

    // Lowest-index hit wins: scan downward so lower indices overwrite higher ones
    always_comb begin
        hit_any    = 1'b0;
        hit_onehot = '0;
        hit_wait   = '0;
        hit_off    = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_any       = 1'b1;
                hit_onehot    = '0;
                hit_onehot[i] = 1'b1;
                hit_wait      = REGION_WAIT[i*4 +: 4];
                hit_off       = cpu_addr_i - REGION_BASE[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Read-data mux over the one-hot select, plus the error status word layout
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            sel_rdata = sel_rdata | rdata_masked[i];
        end
        err_status           = '0;
        err_status[7:0]      = err_cnt_q;
        err_status[DATA_W-1] = err_sticky_q;
    end

    // Next-state logic: request capture/decode, wait countdown, completion
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        is_wr_d      = is_wr_q;
        miss_d       = miss_q;
        sel_d        = sel_q;
        off_d        = off_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        err_cnt_d    = err_cnt_q;
        err_addr_d   = err_addr_q;
        err_sticky_d = err_sticky_q;
        case (state_q)
            IDLE: begin
                if (cpu_rd_i || cpu_wr_i) begin
                    is_wr_d = cpu_wr_i;
                    wdata_d = cpu_wdata_i;
                    miss_d  = 1'b0;
                    if (cpu_addr_i == ERR_ADDR || cpu_addr_i == ERR_ADDR1) begin
                        state_d = DONE;
                        if (cpu_wr_i) begin
                            rdata_d = '0;
                            if (cpu_addr_i == ERR_ADDR) begin
                                err_cnt_d    = '0;
                                err_addr_d   = '0;
                                err_sticky_d = 1'b0;
                            end
                        end else if (cpu_addr_i == ERR_ADDR) begin
                            rdata_d = err_status;
                        end else begin
                            rdata_d = DATA_W'(err_addr_q);
                        end
                    end else if (hit_any) begin
                        state_d = ACCESS;
                        sel_d   = hit_onehot;
                        off_d   = hit_off;
                        cnt_d   = hit_wait;
                    end else begin
                        // Unmapped: log it, return zero, drop any write data
                        state_d      = DONE;
                        miss_d       = 1'b1;
                        rdata_d      = '0;
                        err_sticky_d = 1'b1;
                        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                        if (!err_sticky_q) err_addr_d = cpu_addr_i;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    rdata_d = is_wr_q ? '0 : sel_rdata;
                    sel_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                miss_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any access in flight
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            is_wr_q      <= 1'b0;
            miss_q       <= 1'b0;
            sel_q        <= '0;
            off_q        <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_cnt_q    <= '0;
            err_addr_q   <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            is_wr_q      <= is_wr_d;
            miss_q       <= miss_d;
            sel_q        <= sel_d;
            off_q        <= off_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            err_cnt_q    <= err_cnt_d;
            err_addr_q   <= err_addr_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign cpu_rdata_o = rdata_q;
    assign cpu_ready_o = (state_q == DONE);
    assign bus_err_o   = (state_q == DONE) && miss_q;
    assign reg_sel_o   = sel_q;
    assign reg_addr_o  = off_q;
    assign reg_wdata_o = wdata_q;
    assign reg_wr_o    = (state_q == ACCESS) && (cnt_q == 4'd0) && is_wr_q;

endmodule

// File: tb/tb_mmio_region_ctrl.sv
// Directed bench for mmio_region_ctrl using the default region map.
module tb_mmio_region_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [15:0]  cpu_addr = '0;
    logic         cpu_rd = 1'b0;
    logic         cpu_wr = 1'b0;
    logic [15:0]  cpu_wdata = '0;
    logic [15:0]  cpu_rdata;
    logic         cpu_ready;
    logic [7:0]   reg_sel;
    logic [15:0]  reg_addr;
    logic         reg_wr;
    logic [15:0]  reg_wdata;
    logic [127:0] reg_rdata;
    logic         bus_err;

    int n_cmp = 0;
    int n_fail = 0;

    // results of the last access
    int          lat, sel_cyc, wr_cnt, berr;
    logic [15:0] rd, sel_addr, wr_addr, wr_data;
    logic [7:0]  sel_seen;

    mmio_region_ctrl dut (
        .clk_i(clk), .rst_ni(rst_n), .cpu_addr_i(cpu_addr), .cpu_rd_i(cpu_rd),
        .cpu_wr_i(cpu_wr), .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata),
        .cpu_ready_o(cpu_ready), .reg_sel_o(reg_sel), .reg_addr_o(reg_addr),
        .reg_wr_o(reg_wr), .reg_wdata_o(reg_wdata), .reg_rdata_i(reg_rdata),
        .bus_err_o(bus_err)
    );

    always #5 clk = ~clk;

    // Present one request, observe until cpu_ready, then step one more cycle
    task automatic access(input logic [15:0] a, input logic w, input logic [15:0] wd);
        cpu_addr = a; cpu_wr = w; cpu_rd = !w; cpu_wdata = wd;
        lat = -1; sel_cyc = 0; wr_cnt = 0; berr = 0; rd = 'x;
        sel_seen = '0; sel_addr = 'x; wr_addr = 'x; wr_data = 'x;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin cpu_rd = 1'b0; cpu_wr = 1'b0; end
            if (reg_sel != 8'h00) begin sel_cyc++; sel_seen |= reg_sel; sel_addr = reg_addr; end
            if (reg_wr) begin wr_cnt++; wr_addr = reg_addr; wr_data = reg_wdata; end
            if (bus_err) berr++;
            if (cpu_ready) begin lat = c; rd = cpu_rdata; break; end
        end
        n_cmp++;
        if (lat < 0) begin n_fail++; $display("FAIL ready_timeout addr=%h: no cpu_ready within 40 cycles", a); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got %b exp 0", cpu_ready); end
        n_cmp++; if (reg_sel !== 8'h00) begin n_fail++; $display("FAIL rst_sel got %h exp 00", reg_sel); end
        n_cmp++; if ({reg_wr, bus_err} !== 2'b00) begin n_fail++; $display("FAIL rst_wr_err got %b exp 00", {reg_wr, bus_err}); end
        n_cmp++; if (cpu_rdata !== 16'h0000) begin n_fail++; $display("FAIL rst_rdata got %h exp 0000", cpu_rdata); end
        n_cmp++; if (reg_addr !== 16'h0000 || reg_wdata !== 16'h0000) begin n_fail++; $display("FAIL rst_addr_wdata got %h/%h exp 0000/0000", reg_addr, reg_wdata); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_read_hit();
        access(16'h0010, 1'b0, 16'h0);
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL hit_lat got %0d exp 2", lat); end
        n_cmp++; if (sel_seen !== 8'h01 || sel_cyc !== 1) begin n_fail++; $display("FAIL hit_sel got %h x%0d exp 01 x1", sel_seen, sel_cyc); end
        n_cmp++; if (sel_addr !== 16'h0010) begin n_fail++; $display("FAIL hit_addr got %h exp 0010", sel_addr); end
        n_cmp++; if (rd !== 16'hBEEF) begin n_fail++; $display("FAIL hit_rdata got %h exp BEEF", rd); end
        n_cmp++; if (wr_cnt !== 0 || berr !== 0) begin n_fail++; $display("FAIL hit_side got wr=%0d err=%0d exp 0/0", wr_cnt, berr); end
        n_cmp++; if (cpu_rdata !== 16'hBEEF || cpu_ready !== 1'b0) begin n_fail++; $display("FAIL hit_hold got %h rdy=%b exp BEEF rdy=0", cpu_rdata, cpu_ready); end
    endtask

    task automatic test_write_wait();
        access(16'h2401, 1'b1, 16'h1234);
        n_cmp++; if (lat !== 5) begin n_fail++; $display("FAIL wr_lat got %0d exp 5", lat); end
        n_cmp++; if (sel_seen !== 8'h04 || sel_cyc !== 4) begin n_fail++; $display("FAIL wr_sel got %h x%0d exp 04 x4", sel_seen, sel_cyc); end
        n_cmp++; if (wr_cnt !== 1) begin n_fail++; $display("FAIL wr_strobes got %0d exp 1", wr_cnt); end
        n_cmp++; if (wr_addr !== 16'h0001 || wr_data !== 16'h1234) begin n_fail++; $display("FAIL wr_payload got %h/%h exp 0001/1234", wr_addr, wr_data); end
        n_cmp++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL wr_rdata got %h exp 0000", rd); end
    endtask

    task automatic test_unmapped();
        for (int k = 0; k < 2; k++) begin
            access(16'hF000, 1'b0, 16'h0);
            n_cmp++; if (lat !== 1 || berr !== 1 || sel_cyc !== 0) begin n_fail++; $display("FAIL miss%0d got lat=%0d err=%0d sel=%0d exp 1/1/0", k, lat, berr, sel_cyc); end
            n_cmp++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL miss%0d_rdata got %h exp 0000", k, rd); end
        end
        access(16'h48F0, 1'b0, 16'h0);
        n_cmp++; if (rd !== 16'h8002 || lat !== 1 || berr !== 0) begin n_fail++; $display("FAIL err_status got %h lat=%0d err=%0d exp 8002/1/0", rd, lat, berr); end
        // a later miss must not replace the first logged address
        access(16'hE000, 1'b1, 16'h5555);
        n_cmp++; if (berr !== 1 || wr_cnt !== 0) begin n_fail++; $display("FAIL miss_wr got err=%0d wr=%0d exp 1/0", berr, wr_cnt); end
        access(16'h48F1, 1'b0, 16'h0);
        n_cmp++; if (rd !== 16'hF000) begin n_fail++; $display("FAIL err_addr got %h exp F000", rd); end
    endtask

    task automatic test_clear_saturate();
        int tot;
        access(16'h48F0, 1'b1, 16'hABCD);
        n_cmp++; if (lat !== 1 || berr !== 0 || wr_cnt !== 0) begin n_fail++; $display("FAIL clr_wr got lat=%0d err=%0d wr=%0d exp 1/0/0", lat, berr, wr_cnt); end
        access(16'h48F0, 1'b0, 16'h0);
        n_cmp++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL clr_status got %h exp 0000", rd); end
        access(16'h48F1, 1'b0, 16'h0);
        n_cmp++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL clr_addr got %h exp 0000", rd); end
        tot = 0;
        for (int k = 0; k < 300; k++) begin
            access(16'hF800, 1'b0, 16'h0);
            tot += berr;
        end
        n_cmp++; if (tot !== 300) begin n_fail++; $display("FAIL sat_berr got %0d exp 300", tot); end
        access(16'h48F0, 1'b0, 16'h0);
        n_cmp++; if (rd !== 16'h80FF) begin n_fail++; $display("FAIL sat_status got %h exp 80FF", rd); end
    endtask

    task automatic test_overlap();
        access(16'h4800, 1'b0, 16'h0);
        n_cmp++; if (sel_seen !== 8'h02) begin n_fail++; $display("FAIL ovl_sel got %h exp 02", sel_seen); end
        n_cmp++; if (rd !== 16'hA001 || lat !== 3) begin n_fail++; $display("FAIL ovl_read got %h lat=%0d exp A001/3", rd, lat); end
    endtask

    task automatic test_back_to_back();
        access(16'h8004, 1'b0, 16'h0);
        n_cmp++; if (rd !== 16'hA004 || lat !== 2 || sel_addr !== 16'h0004) begin n_fail++; $display("FAIL b2b_a got %h lat=%0d off=%h exp A004/2/0004", rd, lat, sel_addr); end
        access(16'hC3FF, 1'b0, 16'h0);
        n_cmp++; if (rd !== 16'hA007 || lat !== 3 || sel_addr !== 16'h03FF) begin n_fail++; $display("FAIL b2b_b got %h lat=%0d off=%h exp A007/3/03FF", rd, lat, sel_addr); end
        access(16'hA080, 1'b1, 16'h00F0);
        n_cmp++; if (lat !== 4 || sel_seen !== 8'h40 || wr_addr !== 16'h0080) begin n_fail++; $display("FAIL b2b_c got lat=%0d sel=%h off=%h exp 4/40/0080", lat, sel_seen, wr_addr); end
    endtask

    task automatic test_reset_mid();
        int bad;
        cpu_addr = 16'h9003; cpu_wr = 1'b1; cpu_rd = 1'b0; cpu_wdata = 16'h7777;
        @(posedge clk); #1;
        cpu_wr = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (reg_sel !== 8'h20) begin n_fail++; $display("FAIL mid_sel got %h exp 20", reg_sel); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (reg_sel !== 8'h00) begin n_fail++; $display("FAIL mid_rst_sel got %h exp 00", reg_sel); end
        bad = 0;
        for (int k = 0; k < 8; k++) begin
            if (k == 2) rst_n = 1'b1;
            @(posedge clk); #1;
            if (reg_wr || cpu_ready) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL mid_abort got %0d strobe cycles exp 0", bad); end
        access(16'h0010, 1'b0, 16'h0);
        n_cmp++; if (rd !== 16'hBEEF || lat !== 2) begin n_fail++; $display("FAIL mid_after got %h lat=%0d exp BEEF/2", rd, lat); end
        access(16'h48F0, 1'b0, 16'h0);
        n_cmp++; if (rd !== 16'h0000) begin n_fail++; $display("FAIL mid_errlog got %h exp 0000", rd); end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) reg_rdata[i*16 +: 16] = 16'(16'hA000 + i);
        reg_rdata[15:0] = 16'hBEEF;
        test_reset();
        test_read_hit();
        test_write_wait();
        test_unmapped();
        test_clear_saturate();
        test_overlap();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
